// File: rtl/bidir_serializer.sv
// Parallel-to-serial shifter, MSB- or LSB-first per word; first bit visible the cycle after load, done after WIDTH consumed bits.
// shift_en low freezes the word; load_ready reopens only in IDLE or on the consumed last bit, so back-to-back words leave no gap.
module bidir_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             direction,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic             last;
  logic             handshake;

  assign last      = (state == SHIFT) && (cnt == '0);
  assign handshake = load_valid && load_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (handshake) state_n = SHIFT;
      SHIFT:   if (last && shift_en) state_n = handshake ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    serial_valid = (state == SHIFT);
    serial_out   = 1'b0;
    if (state == SHIFT) serial_out = dir_q ? sreg[0] : sreg[WIDTH-1];
    done         = last && shift_en;
    load_ready   = (state == IDLE) || (last && shift_en);
  end

  // A reload on the last-bit edge takes priority over the final shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
    end else if (handshake) begin
      sreg  <= load_data;
      cnt   <= CW'(WIDTH - 1);
      dir_q <= direction;
    end else if ((state == SHIFT) && shift_en && (cnt != '0)) begin
      sreg <= dir_q ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
      cnt  <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_bidir_serializer.sv
// Scoreboard bench for bidir_serializer: expected bits are queued at each load and popped as bits are consumed.
module tb_bidir_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         direction;
  logic         load_ready;
  logic         shift_en;
  logic         serial_out;
  logic         serial_valid;
  logic         done;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  bidir_serializer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .direction    (direction),
    .load_ready   (load_ready),
    .shift_en     (shift_en),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic void push_word(input logic [W-1:0] d, input logic dir);
    for (int i = 0; i < W; i++) exp_q.push_back(dir ? d[i] : d[W-1-i]);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b1; load_data = '1; direction = 1'b0; shift_en = 1'b1;
    @(negedge clk);
    #1;
    checks += 4;
    if (serial_out !== 1'b0)   begin failures++; $display("FAIL reset_serial_out got=%b exp=0", serial_out); end
    if (serial_valid !== 1'b0) begin failures++; $display("FAIL reset_serial_valid got=%b exp=0", serial_valid); end
    if (done !== 1'b0)         begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (load_ready !== 1'b1)   begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    next_cycle();
    load_valid = 1'b0;
    reset = 1'b0;
    next_cycle();
    #1;
    checks += 2;
    if (serial_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", serial_valid); end
    if (load_ready !== 1'b1)   begin failures++; $display("FAIL post_reset_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_single_word(input string name, input logic [W-1:0] d, input logic dir);
    logic b;
    load_valid = 1'b1; load_data = d; direction = dir; shift_en = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", name, load_ready); end
    push_word(d, dir);
    next_cycle();
    // Direction and data wiggle mid-word; the latched values must rule.
    load_valid = 1'b0; load_data = ~d; direction = ~dir;
    for (int i = 0; i < W; i++) begin
      #1;
      b = exp_q.pop_front();
      checks += 3;
      if (serial_valid !== 1'b1) begin failures++; $display("FAIL %s_valid[%0d] got=%b exp=1", name, i, serial_valid); end
      if (serial_out !== b)      begin failures++; $display("FAIL %s_bit[%0d] got=%b exp=%b", name, i, serial_out, b); end
      if (done !== (i == W-1))   begin failures++; $display("FAIL %s_done[%0d] got=%b exp=%b", name, i, done, (i == W-1)); end
      next_cycle();
    end
    #1;
    checks += 2;
    if (serial_valid !== 1'b0) begin failures++; $display("FAIL %s_after_valid got=%b exp=0", name, serial_valid); end
    if (done !== 1'b0)         begin failures++; $display("FAIL %s_after_done got=%b exp=0", name, done); end
  endtask

  task automatic test_back_to_back();
    logic b;
    load_valid = 1'b1; load_data = 4'b1100; direction = 1'b0; shift_en = 1'b1;
    push_word(4'b1100, 1'b0);
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 2*W; i++) begin
      if (i == W-1) begin
        load_valid = 1'b1; load_data = 4'b0011; direction = 1'b1;
      end else begin
        load_valid = 1'b0; load_data = 4'b1111; direction = 1'b0;
      end
      #1;
      b = exp_q.pop_front();
      checks += 4;
      if (serial_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, serial_valid); end
      if (serial_out !== b)      begin failures++; $display("FAIL b2b_bit[%0d] got=%b exp=%b", i, serial_out, b); end
      if (done !== (i == W-1 || i == 2*W-1))
        begin failures++; $display("FAIL b2b_done[%0d] got=%b", i, done); end
      if (load_ready !== (i == W-1 || i == 2*W-1))
        begin failures++; $display("FAIL b2b_ready[%0d] got=%b", i, load_ready); end
      if (i == W-1) push_word(4'b0011, 1'b1);
      next_cycle();
    end
    load_valid = 1'b0;
    #1;
    checks++;
    if (serial_valid !== 1'b0) begin failures++; $display("FAIL b2b_after_valid got=%b exp=0", serial_valid); end
  endtask

  task automatic test_stall();
    logic b;
    int   consumed;
    load_valid = 1'b1; load_data = 4'b1010; direction = 1'b0; shift_en = 1'b1;
    push_word(4'b1010, 1'b0);
    next_cycle();
    load_valid = 1'b0;
    consumed = 0;
    for (int cyc = 0; cyc < W + 3; cyc++) begin
      shift_en = !(cyc >= 2 && cyc < 5);
      #1;
      b = exp_q[0];
      checks += 3;
      if (serial_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", cyc, serial_valid); end
      if (serial_out !== b)      begin failures++; $display("FAIL stall_bit[%0d] got=%b exp=%b", cyc, serial_out, b); end
      if (done !== (shift_en && consumed == W-1))
        begin failures++; $display("FAIL stall_done[%0d] got=%b exp=%b", cyc, done, (shift_en && consumed == W-1)); end
      if (shift_en) begin
        void'(exp_q.pop_front());
        consumed++;
      end
      next_cycle();
    end
    shift_en = 1'b1;
    #1;
    checks++;
    if (serial_valid !== 1'b0) begin failures++; $display("FAIL stall_after_valid got=%b exp=0", serial_valid); end
  endtask

  task automatic test_protect_and_reset();
    logic b;
    load_valid = 1'b1; load_data = 4'b1001; direction = 1'b0; shift_en = 1'b1;
    push_word(4'b1001, 1'b0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      load_valid = (i == 1); load_data = 4'b1111;
      #1;
      b = exp_q.pop_front();
      checks += 2;
      if (serial_out !== b)    begin failures++; $display("FAIL protect_bit[%0d] got=%b exp=%b", i, serial_out, b); end
      if (load_ready !== 1'b0) begin failures++; $display("FAIL protect_ready[%0d] got=%b exp=0", i, load_ready); end
      next_cycle();
    end
    load_valid = 1'b0;
    #1;
    b = exp_q[0];
    checks++;
    if (serial_out !== b) begin failures++; $display("FAIL protect_bit[2] got=%b exp=%b", serial_out, b); end
    reset = 1'b1;
    #1;
    checks += 4;
    if (serial_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", serial_valid); end
    if (serial_out !== 1'b0)   begin failures++; $display("FAIL midreset_out got=%b exp=0", serial_out); end
    if (done !== 1'b0)         begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
    if (load_ready !== 1'b1)   begin failures++; $display("FAIL midreset_ready got=%b exp=1", load_ready); end
    exp_q.delete();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 3;
      if (serial_valid !== 1'b0) begin failures++; $display("FAIL postreset_valid[%0d] got=%b exp=0", i, serial_valid); end
      if (done !== 1'b0)         begin failures++; $display("FAIL postreset_done[%0d] got=%b exp=0", i, done); end
      if (load_ready !== 1'b1)   begin failures++; $display("FAIL postreset_ready[%0d] got=%b exp=1", i, load_ready); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic b;
    logic exp_ready;
    int   words = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      shift_en   = ($urandom_range(0, 3) != 0);
      load_valid = $urandom_range(0, 1);
      load_data  = W'($urandom);
      direction  = $urandom_range(0, 1);
      #1;
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && shift_en);
      checks += 3;
      if (serial_valid !== (exp_q.size() != 0))
        begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", cyc, serial_valid, (exp_q.size() != 0)); end
      if (load_ready !== exp_ready)
        begin failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", cyc, load_ready, exp_ready); end
      if (done !== (exp_q.size() == 1 && shift_en))
        begin failures++; $display("FAIL rand_done[%0d] got=%b exp=%b", cyc, done, (exp_q.size() == 1 && shift_en)); end
      if (exp_q.size() != 0) begin
        b = exp_q[0];
        checks++;
        if (serial_out !== b) begin failures++; $display("FAIL rand_bit[%0d] got=%b exp=%b", cyc, serial_out, b); end
        if (shift_en) void'(exp_q.pop_front());
      end
      if (load_valid && exp_ready) begin
        push_word(load_data, direction);
        words++;
      end
      next_cycle();
    end
    checks++;
    if (words < 10) begin failures++; $display("FAIL rand_words got=%0d exp>=10", words); end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word("msb", 4'b1011, 1'b0);
    test_single_word("lsb", 4'b1011, 1'b1);
    test_back_to_back();
    test_stall();
    test_protect_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
